// File: rtl/pe_sched_pkg.sv
// Shared definitions for the attention-engine job scheduler: FSM encoding,
// default timeout and the requester-ID width helper.
package pe_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_RESP  = 2'd2,
      ST_FLUSH = 2'd3
   } state_t;

   localparam int DEF_TIMEOUT_CYC = 2047;

   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pe_attn_job_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches req starting at ptr and
// returns a one-hot grant plus its encoded index.
module rr_arbiter
   import pe_sched_pkg::*;
#(
   parameter int N = 4,
   localparam int ID_W = id_w(N)
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] ptr,
   input  logic            enable,
   output logic [N-1:0]    grant,
   output logic [ID_W-1:0] grant_id,
   output logic            any_grant
);

   int idx;

   always_comb begin
      grant     = '0;
      grant_id  = '0;
      any_grant = 1'b0;
      idx       = 0;
      for (int i = 0; i < N; i++) begin
         idx = (int'(ptr) + i) % N;
         if (enable && !any_grant && req[idx]) begin
            grant[idx] = 1'b1;
            grant_id   = ID_W'(idx);
            any_grant  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pe_attn_job_scheduler.sv
// Time-shares one pe_8x8_top attention engine between NUM_REQ requesters.
// Optional macro PE_SCHED_PERF_CNT_EN adds resp_cycles/jobs_done counters.
module pe_attn_job_scheduler
   import pe_sched_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int DATA_W      = 512,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter int FLUSH_CYC   = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*DATA_W-1:0]     req_key,
   input  logic [NUM_REQ*DATA_W-1:0]     req_value,
   input  logic [NUM_REQ*DATA_W-1:0]     req_query,
   output logic                          resp_valid,
   input  logic                          resp_ready,
   output logic [$clog2(NUM_REQ)-1:0]    resp_id,
   output logic [DATA_W-1:0]             resp_data,
   output logic                          resp_err,
   output logic                          busy,
   output logic                          eng_en,
   output logic                          eng_rst_n,
   output logic [DATA_W-1:0]             eng_key,
   output logic [DATA_W-1:0]             eng_value,
   output logic [DATA_W-1:0]             eng_query,
   input  logic [DATA_W-1:0]             eng_final_res,
   input  logic                          eng_all_done
`ifdef PE_SCHED_PERF_CNT_EN
   ,
   output logic [15:0]                   resp_cycles,
   output logic [31:0]                   jobs_done
`endif
);

   localparam int ID_W = id_w(NUM_REQ);
   localparam int RC_W = $clog2(TIMEOUT_CYC + 1);
   localparam int FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

   state_t            state, state_nx;
   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]   grant_id;
   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   job_id;
   logic              any_grant;
   logic              arb_en;
   logic [RC_W-1:0]   run_cnt;
   logic [FC_W-1:0]   flush_cnt;
   logic              run_tmo;
   logic              run_end;
   logic              resp_hs;
   logic              job_start;

   function automatic logic [RC_W-1:0] sat_inc(input logic [RC_W-1:0] c);
      return (c == {RC_W{1'b1}}) ? c : c + 1'b1;
   endfunction

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req       (req_valid),
      .ptr       (rr_ptr),
      .enable    (arb_en),
      .grant     (grant),
      .grant_id  (grant_id),
      .any_grant (any_grant)
   );

   // Grants are offered only in IDLE and never while reset is asserted.
   assign arb_en     = (state == ST_IDLE) && !rst;
   assign req_ready  = grant;
   assign job_start  = arb_en && any_grant;
   assign run_tmo    = (run_cnt == RC_W'(TIMEOUT_CYC - 1));
   assign run_end    = (state == ST_RUN) && (eng_all_done || run_tmo);
   assign resp_hs    = (state == ST_RESP) && resp_ready;
   assign resp_valid = (state == ST_RESP);
   assign resp_id    = job_id;
   assign busy       = (state != ST_IDLE);

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (any_grant) state_nx = ST_RUN;
         ST_RUN:   if (eng_all_done || run_tmo) state_nx = ST_RESP;
         ST_RESP:  if (resp_ready) state_nx = ST_FLUSH;
         ST_FLUSH: if (flush_cnt == '0) state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   // Engine controls are registered from the next state so they line up
   // exactly with the state they belong to and drop on the reset edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         rr_ptr    <= '0;
         job_id    <= '0;
         run_cnt   <= '0;
         flush_cnt <= '0;
         eng_en    <= 1'b0;
         eng_rst_n <= 1'b0;
      end else begin
         state     <= state_nx;
         eng_en    <= (state_nx == ST_RUN);
         eng_rst_n <= (state_nx != ST_FLUSH);
         if (job_start) begin
            job_id  <= grant_id;
            rr_ptr  <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            run_cnt <= '0;
         end else if (state == ST_RUN) begin
            run_cnt <= sat_inc(run_cnt);
         end
         if (resp_hs)
            flush_cnt <= FC_W'(FLUSH_CYC - 1);
         else if ((state == ST_FLUSH) && (flush_cnt != '0))
            flush_cnt <= flush_cnt - 1'b1;
      end
   end

   // Operand latch at grant; result capture at the end of RUN.
   always_ff @(posedge clk) begin
      if (rst) begin
         eng_key   <= '0;
         eng_value <= '0;
         eng_query <= '0;
         resp_data <= '0;
         resp_err  <= 1'b0;
      end else begin
         if (job_start) begin
            eng_key   <= req_key  [int'(grant_id)*DATA_W +: DATA_W];
            eng_value <= req_value[int'(grant_id)*DATA_W +: DATA_W];
            eng_query <= req_query[int'(grant_id)*DATA_W +: DATA_W];
         end
         if (run_end) begin
            if (eng_all_done) begin
               resp_data <= eng_final_res;
               resp_err  <= 1'b0;
            end else begin
               resp_data <= '0;
               resp_err  <= 1'b1;
            end
         end
      end
   end

`ifdef PE_SCHED_PERF_CNT_EN
   logic [15:0] cyc_q;
   logic [31:0] jobs_q;

   function automatic logic [15:0] cyc_sat16(input logic [RC_W-1:0] c);
      longint v;
      v = longint'(c) + 1;
      return (v > 65535) ? 16'hFFFF : 16'(v);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_q  <= '0;
         jobs_q <= '0;
      end else begin
         if (run_end) cyc_q <= cyc_sat16(run_cnt);
         if (resp_hs) jobs_q <= jobs_q + 1'b1;
      end
   end

   assign resp_cycles = cyc_q;
   assign jobs_done   = jobs_q;
`endif

endmodule

// File: doc/pe_attn_job_scheduler.md
Name: pe_attn_job_scheduler

Overview:
- Shares one pe_8x8_top attention engine between NUM_REQ requesters, such as attention heads or DMA channels.
- Arbitrates round-robin and latches the winner's key/value/query operands (512 b each).
- Sequences the engine's en/rst_n, waits for all_done (or a timeout), captures final_res and returns it with the requester ID over a valid/ready response port.
- Sits directly in front of pe_8x8_top. It is the only block that drives the engine.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 512, width of each operand and result bus.
- TIMEOUT_CYC, 2047, maximum RUN cycles before a job is aborted.
- FLUSH_CYC, 2, cycles eng_en/eng_rst_n are held low between jobs (minimum 1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high (one clock; reset is synchronous and active-high).
- req_valid  in  NUM_REQ  per-requester job request.
- req_ready  out  NUM_REQ  one-hot grant/accept.
- req_key  in  NUM_REQ*DATA_W  flattened; requester r occupies [r*DATA_W +: DATA_W].
- req_value  in  NUM_REQ*DATA_W  same layout as req_key.
- req_query  in  NUM_REQ*DATA_W  same layout as req_key.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_id  out  $clog2(NUM_REQ)  requester index of this result.
- resp_data  out  DATA_W  captured final_res.
- resp_err  out  1  job aborted by timeout.
- busy  out  1  state != IDLE.
- eng_en  out  1  to pe_8x8_top en.
- eng_rst_n  out  1  to pe_8x8_top rst_n.
- eng_key  out  DATA_W  to pe_8x8_top key.
- eng_value  out  DATA_W  to pe_8x8_top value.
- eng_query  out  DATA_W  to pe_8x8_top query.
- eng_final_res  in  DATA_W  from pe_8x8_top.
- eng_all_done  in  1  from pe_8x8_top.

Behaviour:
- Reset values:
  - state=IDLE, rr_ptr=0.
  - req_ready=0, resp_valid=0, resp_id=0, resp_data=0, resp_err=0, busy=0.
  - eng_en=0, eng_rst_n=0, eng_key/value/query=0.
  - Reset asserted in any state aborts the job with no response; the engine is held in reset.
- FSM: IDLE -> RUN -> RESP -> FLUSH -> IDLE.
- IDLE:
  - Winner = first r with req_valid[r]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready[winner]=1 combinationally in the same cycle; all other bits are 0.
  - On that edge: latch the winner's operands into eng_key/value/query, set job_id=winner, set rr_ptr=(winner+1) mod NUM_REQ, clear run_cnt, go to RUN.
  - No valid request: remain in IDLE; rr_ptr unchanged.
  - eng_rst_n=1 and eng_en=0 in IDLE.
- RUN:
  - eng_en=1, eng_rst_n=1.
  - Operands are stable for the whole state; run_cnt increments each cycle.
  - If eng_all_done=1: capture eng_final_res into resp_data, set resp_err=0, go to RESP.
  - Else if run_cnt==TIMEOUT_CYC-1: set resp_data=0, resp_err=1, go to RESP.
  - all_done on the timeout cycle wins (err=0).
- RESP:
  - resp_valid=1; resp_id, resp_data and resp_err are held stable until resp_ready=1.
  - eng_en=0, so the engine self-clears.
  - Handshake completes on the edge where resp_valid && resp_ready; then go to FLUSH and load flush_cnt=FLUSH_CYC-1.
  - resp_ready high before resp_valid has no effect.
- FLUSH:
  - eng_en=0, eng_rst_n=0, resp_valid=0.
  - Counts down; go to IDLE when flush_cnt==0.
  - Guarantees the engine's flag and counter state is cleared before the next job.
- Latency: request accept at cycle 0; eng_en high from cycle 1; resp_valid the cycle after all_done is seen; next grant no earlier than FLUSH_CYC+1 cycles after the response handshake.
- A requester dropping req_valid before its grant is allowed and is simply skipped.
- req_ready is never asserted outside IDLE.
- Counters: run_cnt is $clog2(TIMEOUT_CYC+1) bits and saturates, never wraps. rr_ptr wraps modulo NUM_REQ.

Optional Feature:
- Macro PE_SCHED_PERF_CNT_EN.
- Defined:
  - Adds output resp_cycles [15:0] = RUN cycles of the returned job (captured run_cnt+1, saturating at 16'hFFFF), valid with resp_valid.
  - Adds output jobs_done [31:0], which increments on every response handshake (wraps) and is cleared by rst.
- Undefined: neither port exists and no counters are synthesised.

Decomposition:
- Shared package pe_sched_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_RESP=2'd2, ST_FLUSH=2'd3;
  - the default TIMEOUT_CYC;
  - the ID width function.
- One sub-module: rr_arbiter (parameter N).
  - Inputs: req[N], ptr, enable.
  - Outputs: one-hot grant, encoded grant_id, any_grant.
  - Purely combinational; pointer storage stays in the scheduler.

Test Plan:
- Single job: req_valid=4'b0001, engine model asserts all_done 300 cycles after en -> req_ready=4'b0001 for 1 cycle; resp_valid with resp_id=0, resp_data=model final_res, resp_err=0; eng_rst_n low exactly 2 cycles afterwards.
- Round-robin: req_valid=4'b1111 held for 4 jobs -> grant order 0,1,2,3, then 0 again; operands in each RUN match the granted requester.
- Timeout: engine never asserts all_done -> resp_err=1 and resp_data=0 after exactly 2047 RUN cycles; next job proceeds normally.
- Backpressure: resp_ready=0 for 50 cycles -> resp_valid/resp_id/resp_data stable; eng_en=0; no req_ready asserted; completes on the first resp_ready=1.
- Reset mid-RUN: rst=1 at cycle 100 of a job -> next edge: eng_en=0, eng_rst_n=0, busy=0, resp_valid=0, rr_ptr=0; no response is emitted for the aborted job.
- Edge case: all_done and timeout on the same cycle -> resp_err=0 and data captured. With PE_SCHED_PERF_CNT_EN, resp_cycles=2047.
